// File: rtl/imem_loader.sv
// Per-thread instruction banks with a byte-stream boot loader.
// Fetches return NOP until an end frame (A5,FF) has been accepted.
package types;
  localparam int NUM_Threads = 4;
endpackage

module imem_loader #(
  parameter int NUM_Threads = types::NUM_Threads,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_Threads-1:0][31:0] pc_o,
  output logic [NUM_Threads-1:0][31:0] rom_ins,
  input  logic                        ld_valid,
  input  logic [7:0]                  ld_data,
  output logic                        ld_ready,
  output logic                        boot_done,
  output logic                        ld_err,
  output logic [2:0]                  ld_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int TW = (NUM_Threads > 1) ? $clog2(NUM_Threads) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshake: a byte moves on a rising edge where ld_valid && ld_ready;
  // ld_data is only looked at on that edge, ld_valid may drop at any time.
  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_TID    = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_CNT_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tid_q, tid_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;

  logic          xfer;
  logic          we;
  logic [15:0]   count16;

  logic [31:0]   mem [NUM_Threads][DEPTH_WORDS];

  assign ld_ready  = (state_q != ST_DONE) && (state_q != ST_ERR);
  assign boot_done = (state_q == ST_DONE);
  assign ld_err    = (state_q == ST_ERR);
  assign ld_state  = state_q;
  assign xfer      = ld_valid && ld_ready;
  assign count16   = {ld_data, cnt_lo_q};

  always_comb begin
    state_d  = state_q;
    tid_d    = tid_q;
    cnt_lo_d = cnt_lo_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    word_d   = word_q;
    csum_d   = csum_q;
    we       = 1'b0;
    if (xfer) begin
      unique case (state_q)
        ST_SYNC: begin
          if (ld_data == 8'hA5) begin
            state_d = ST_TID;
            csum_d  = 8'h00;
          end
        end
        ST_TID: begin
          if (ld_data == 8'hFF) begin
            state_d = ST_DONE;
          end else if ({24'd0, ld_data} < 32'(NUM_Threads)) begin
            state_d = ST_CNT_LO;
            tid_d   = ld_data[TW-1:0];
            csum_d  = ld_data;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_CNT_LO: begin
          cnt_lo_d = ld_data;
          csum_d   = csum_q ^ ld_data;
          state_d  = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          csum_d = csum_q ^ ld_data;
          cnt_d  = count16[AW:0];
          idx_d  = '0;
          lane_d = 2'd0;
          if ({1'b0, count16} > 17'(DEPTH_WORDS)) state_d = ST_ERR;
          else if (count16 == 16'd0)              state_d = ST_CSUM;
          else                                    state_d = ST_DATA;
        end
        ST_DATA: begin
          csum_d = csum_q ^ ld_data;
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: word_d[7:0]   = ld_data;
            2'd1: word_d[15:8]  = ld_data;
            2'd2: word_d[23:16] = ld_data;
            2'd3: begin
              we    = 1'b1;
              idx_d = idx_q + 1'b1;
              if ({1'b0, idx_q} == cnt_q - 1'b1) state_d = ST_CSUM;
            end
          endcase
        end
        ST_CSUM: begin
          state_d = (ld_data == csum_q) ? ST_SYNC : ST_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      tid_q    <= '0;
      cnt_lo_q <= 8'h00;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= 2'd0;
      word_q   <= 24'h0;
      csum_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      tid_q    <= tid_d;
      cnt_lo_q <= cnt_lo_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      csum_q   <= csum_d;
    end
  end

  // Bank contents are deliberately not reset so a mid-frame reset keeps loaded words.
  always_ff @(posedge clk) begin
    if (we) mem[tid_q][idx_q] <= {ld_data, word_q};
  end

  always_comb begin
    for (int t = 0; t < NUM_Threads; t++) begin
      rom_ins[t] = NOP;
      if (boot_done && (pc_o[t][1:0] == 2'b00) && (pc_o[t][31:AW+2] == '0))
        rom_ins[t] = mem[t][pc_o[t][AW+1:2]];
    end
  end

endmodule
